// File: rtl/rvmyth_pll_pkg.sv
// Shared constants for the RVMyth + PLL digital top: RV32I subset encodings, decode helpers
// and the fixed sum-of-0..9 ROM program.
package rvmyth_pll_pkg;

    localparam int ROM_DEPTH  = 16;
    localparam int DMEM_WORDS = 8;
    localparam int SYNC_STG   = 2;
    localparam int DMEM_AW    = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {
        K_NOP,
        K_ADD,
        K_ADDI,
        K_BLT,
        K_BEQ,
        K_SW,
        K_LW
    } op_kind_t;

    // BEQ x0,x0,0: a self-loop that parks the PC
    localparam instr_t HALT_INSN = 32'h0000_0063;

    localparam instr_t ROM_PROG [ROM_DEPTH] = '{
        32'h0000_0533,  // ADD  x10,x0,x0
        32'h0005_0733,  // ADD  x14,x10,x0
        32'h00A5_0613,  // ADDI x12,x10,10
        32'h0005_06B3,  // ADD  x13,x10,x0
        32'h00E6_8733,  // ADD  x14,x13,x14
        32'h0016_8693,  // ADDI x13,x13,1
        32'hFEC6_CCE3,  // BLT  x13,x12,-8
        32'h0007_0533,  // ADD  x10,x14,x0
        32'h00A0_2223,  // SW   x10,4(x0)
        32'h0040_2783,  // LW   x15,4(x0)
        HALT_INSN,
        HALT_INSN,
        HALT_INSN,
        HALT_INSN,
        HALT_INSN,
        HALT_INSN
    };

    function automatic logic [31:0] imm_i(input instr_t insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input instr_t insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input instr_t insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    // Anything outside the supported subset retires as a plain PC+4 no-op
    function automatic op_kind_t decode_op(input instr_t insn);
        op_kind_t kind;
        kind = K_NOP;
        case (insn[6:0])
            OP_REG:    if (insn[14:12] == F3_ADD && insn[31:25] == 7'd0) kind = K_ADD;
            OP_IMM:    if (insn[14:12] == F3_ADD) kind = K_ADDI;
            OP_BRANCH: begin
                if (insn[14:12] == F3_BEQ)      kind = K_BEQ;
                else if (insn[14:12] == F3_BLT) kind = K_BLT;
            end
            OP_STORE:  if (insn[14:12] == F3_WORD) kind = K_SW;
            OP_LOAD:   if (insn[14:12] == F3_WORD) kind = K_LW;
            default:   kind = K_NOP;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/rvmyth_pll_sync.sv
// Brings the PLL reference into the VCO domain and raises a sticky 'started' on its first
// genuine rising edge after reset.
module rvmyth_pll_sync
    import rvmyth_pll_pkg::*;
#(
    parameter int STAGES = SYNC_STG
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_in,
    output logic started
);

    localparam int FILL_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] sync_q;
    logic [FILL_W-1:0] fill_q;
    logic              seen_low_q;
    logic              started_q;
    logic              sync_valid;
    logic              ref_s;

    // The last stage only holds a real REF sample once the chain has been filled since reset;
    // a start additionally needs a real low sample first, so REF high at release is ignored.
    assign sync_valid = (fill_q == FILL_W'(STAGES));
    assign ref_s      = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            fill_q     <= '0;
            seen_low_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ref_in};
            if (!sync_valid) fill_q <= fill_q + FILL_W'(1);
            if (sync_valid && !ref_s) seen_low_q <= 1'b1;
            if (sync_valid && seen_low_q && ref_s) started_q <= 1'b1;
        end
    end

    assign started = started_q;

endmodule

// File: rtl/rvmyth_pll_core.sv
// Digital top of the RVMyth + PLL integration: a single-cycle RV32I-subset core clocked by the
// VCO, running the ROM program and driving the DAC bus from x14.
module rvmyth_pll_core
    import rvmyth_pll_pkg::*;
(
    input  logic       VCO_IN,
    input  logic       reset,
    input  logic       EN_VCO,
    input  logic       REF,
    input  logic       VDDA,
    input  logic       VDDD,
    input  logic       VSSA,
    input  logic       VSSD,
    output logic [9:0] out
);

    logic               started;
    logic               run;
    logic [31:0]        pc;
    logic [31:0]        regs [32];
    logic [31:0]        dmem [DMEM_WORDS];

    instr_t             instr;
    op_kind_t           kind;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        rs1_val;
    logic [31:0]        rs2_val;
    logic [31:0]        mem_addr;
    logic [DMEM_AW-1:0] mem_idx;
    logic [31:0]        pc_next;
    logic [31:0]        wr_data;
    logic               wr_en;
    logic               st_en;
    logic               unused_ok;

    rvmyth_pll_sync #(
        .STAGES (SYNC_STG)
    ) u_sync (
        .clk     (VCO_IN),
        .rst_n   (reset),
        .ref_in  (REF),
        .started (started)
    );

    assign run = EN_VCO & started;

    // Fetch beyond the 64-byte ROM window reads as halt
    assign instr = (pc[31:6] == '0) ? ROM_PROG[pc[5:2]] : HALT_INSN;
    assign kind  = decode_op(instr);
    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign mem_addr = rs1_val + ((kind == K_SW) ? imm_s(instr) : imm_i(instr));
    assign mem_idx  = mem_addr[DMEM_AW+1:2];

    always_comb begin
        pc_next = pc + 32'd4;
        wr_en   = 1'b0;
        wr_data = '0;
        st_en   = 1'b0;
        case (kind)
            K_ADD: begin
                wr_en   = 1'b1;
                wr_data = rs1_val + rs2_val;
            end
            K_ADDI: begin
                wr_en   = 1'b1;
                wr_data = rs1_val + imm_i(instr);
            end
            K_BLT: begin
                if ($signed(rs1_val) < $signed(rs2_val)) pc_next = pc + imm_b(instr);
            end
            K_BEQ: begin
                if (rs1_val == rs2_val) pc_next = pc + imm_b(instr);
            end
            K_SW: begin
                st_en = 1'b1;
            end
            K_LW: begin
                wr_en   = 1'b1;
                wr_data = dmem[mem_idx];
            end
            default: begin
                pc_next = pc + 32'd4;
            end
        endcase
    end

    // Every piece of architectural state advances together, and only on run cycles
    always_ff @(posedge VCO_IN or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int j = 0; j < DMEM_WORDS; j++) dmem[j] <= '0;
        end else if (run) begin
            pc <= pc_next;
            if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
            if (st_en) dmem[mem_idx] <= rs2_val;
        end
    end

    assign out = regs[14][9:0];

    // Supply pins are connectivity-only
    assign unused_ok = &{1'b0, VDDA, VDDD, VSSA, VSSD,
                         mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

endmodule

// File: tb/tb_rvmyth_pll_core.sv
// Directed bench for rvmyth_pll_core: start gating, full sum sequence, stall, async reset
// replay and supply-pin independence, checked against a small cycle model of the program.
module tb_rvmyth_pll_core;

    logic       VCO_IN = 1'b0;
    logic       reset;
    logic       EN_VCO;
    logic       REF;
    logic       VDDA;
    logic       VDDD;
    logic       VSSA;
    logic       VSSD;
    logic [9:0] out;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    rvmyth_pll_core dut (
        .VCO_IN (VCO_IN),
        .reset  (reset),
        .EN_VCO (EN_VCO),
        .REF    (REF),
        .VDDA   (VDDA),
        .VDDD   (VDDD),
        .VSSA   (VSSA),
        .VSSD   (VSSD),
        .out    (out)
    );

    always #5 VCO_IN = ~VCO_IN;

    // x14 after n run cycles: iteration k adds k at run cycle 5+3k, ten iterations in all
    function automatic logic [31:0] exp_out(input int cyc);
        int k;
        if (cyc < 5) return 32'd0;
        k = (cyc - 5) / 3;
        if (k > 9) k = 9;
        return 32'(k * (k + 1) / 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ref_v, input logic en_v, input int cycles,
                                 input string tag);
        REF    = ref_v;
        EN_VCO = en_v;
        repeat (cycles) begin
            @(negedge VCO_IN);
            checkOutput({tag, "_out"}, {22'd0, out}, 32'd0);
            checkOutput({tag, "_pc"}, dut.pc, 32'd0);
        end
    endtask

    task automatic start_core();
        int lat;
        lat = 0;
        REF = 1'b1;
        while (lat < 20) begin
            @(posedge VCO_IN);
            lat++;
            @(negedge VCO_IN);
            if (dut.pc == 32'd4) break;
        end
        checkOutput("start_lat", 32'(lat), 32'd4);
        n = 1;
        checkOutput("out_seq", {22'd0, out}, exp_out(n));
    endtask

    task automatic run_to(input int target, input bit toggle);
        int guard;
        guard = 0;
        while (n < target && guard < 1000) begin
            @(posedge VCO_IN);
            if (EN_VCO) n++;
            guard++;
            @(negedge VCO_IN);
            if (toggle) {VDDA, VDDD, VSSA, VSSD} = 4'($urandom);
            checkOutput("out_seq", {22'd0, out}, exp_out(n));
        end
        checkOutput("run_reached", 32'(n), 32'(target));
    endtask

    initial begin
        reset  = 1'b0;
        EN_VCO = 1'b1;
        REF    = 1'b0;
        VDDA   = 1'b1;
        VDDD   = 1'b1;
        VSSA   = 1'b0;
        VSSD   = 1'b0;

        // Held in reset with REF toggling across clock edges
        repeat (4) begin
            #2 REF = ~REF;
            #2;
            checkOutput("rst_out", {22'd0, out}, 32'd0);
            checkOutput("rst_pc", dut.pc, 32'd0);
            #1;
        end
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 50, "idle");

        // REF already high at reset release must not start the core
        reset = 1'b0;
        REF   = 1'b1;
        @(negedge VCO_IN);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 20, "refhigh");
        applyStimulus(1'b0, 1'b1, 5, "reflow");

        start_core();
        run_to(32, 1'b0);
        checkOutput("out_n32", {22'd0, out}, 32'd45);
        run_to(400, 1'b0);
        checkOutput("x10_final", dut.regs[10], 32'd45);
        checkOutput("dmem1_final", dut.dmem[1], 32'd45);
        checkOutput("x15_final", dut.regs[15], 32'd45);
        checkOutput("pc_final", dut.pc, 32'd40);

        // Stall while out=10, then resume
        reset = 1'b0;
        @(negedge VCO_IN);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 5, "rerun");
        start_core();
        run_to(17, 1'b0);
        checkOutput("pre_stall_out", {22'd0, out}, 32'd10);
        checkOutput("pre_stall_pc", dut.pc, 32'd20);
        EN_VCO = 1'b0;
        repeat (20) begin
            @(negedge VCO_IN);
            checkOutput("stall_out", {22'd0, out}, 32'd10);
            checkOutput("stall_pc", dut.pc, 32'd20);
        end
        EN_VCO = 1'b1;
        run_to(20, 1'b0);
        checkOutput("resume_out", {22'd0, out}, 32'd15);
        run_to(26, 1'b0);
        checkOutput("pre_rst_out", {22'd0, out}, 32'd28);

        // Asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_out", {22'd0, out}, 32'd0);
        checkOutput("async_rst_pc", dut.pc, 32'd0);
        @(negedge VCO_IN);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 20, "post_rst");
        applyStimulus(1'b0, 1'b1, 5, "post_rst_low");

        // Replay with the supply pins toggling
        start_core();
        run_to(60, 1'b1);
        checkOutput("supply_out", {22'd0, out}, 32'd45);
        checkOutput("supply_pc", dut.pc, 32'd40);
        checkOutput("supply_x15", dut.regs[15], 32'd45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
